// File: rtl/regfile_arbiter_if.sv
// Core/debug request buses and register-file port of regfile_arbiter.
// d_lock exists only when REGFILE_ARB_LOCK_EN is defined.
interface regfile_arbiter_if;
  logic       c_req;
  logic       d_req;
  logic [1:0] c_op;
  logic [1:0] d_op;
  logic [3:0] c_a;
  logic [3:0] c_b;
  logic [3:0] d_a;
  logic [3:0] d_b;
  logic [7:0] c_data;
  logic [7:0] d_data;
  logic       c_ack;
  logic       d_ack;
  logic [7:0] c_rdata_a;
  logic [7:0] c_rdata_b;
  logic [7:0] d_rdata_a;
  logic [7:0] d_rdata_b;
  logic [3:0] rf_a_select;
  logic [3:0] rf_b_select;
  logic [7:0] rf_din;
  logic [7:0] rf_constant;
  logic       rf_write_en;
  logic       rf_add;
  logic       rf_move;
  logic [7:0] rf_outA;
  logic [7:0] rf_outB;
  logic       busy;
`ifdef REGFILE_ARB_LOCK_EN
  logic       d_lock;
`endif

  modport slave (
`ifdef REGFILE_ARB_LOCK_EN
    input  d_lock,
`endif
    input  c_req, d_req, c_op, d_op, c_a, c_b, d_a, d_b, c_data, d_data,
    input  rf_outA, rf_outB,
    output c_ack, d_ack, c_rdata_a, c_rdata_b, d_rdata_a, d_rdata_b,
    output rf_a_select, rf_b_select, rf_din, rf_constant,
    output rf_write_en, rf_add, rf_move, busy
  );

  modport master (
`ifdef REGFILE_ARB_LOCK_EN
    output d_lock,
`endif
    output c_req, d_req, c_op, d_op, c_a, c_b, d_a, d_b, c_data, d_data,
    output rf_outA, rf_outB,
    input  c_ack, d_ack, c_rdata_a, c_rdata_b, d_rdata_a, d_rdata_b,
    input  rf_a_select, rf_b_select, rf_din, rf_constant,
    input  rf_write_en, rf_add, rf_move, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Arbitrates a core and a debug requester onto one register-file port (IDLE/ISSUE/ACK).
// Optional debug lock is enabled by defining REGFILE_ARB_LOCK_EN.
module regfile_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  regfile_arbiter_if.slave bus
);
  localparam int CW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MOVE  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, ACK = 2'b10} state_t;

  state_t        state_r;
  logic [CW-1:0] starve_r;
  logic          gnt_d_r;
  logic          busy_r;
  logic          c_ack_r;
  logic          d_ack_r;
  logic          we_r;
  logic          add_r;
  logic          move_r;
  logic [3:0]    a_sel_r;
  logic [3:0]    b_sel_r;
  logic [7:0]    data_r;
  logic [7:0]    c_rd_a_r;
  logic [7:0]    c_rd_b_r;
  logic [7:0]    d_rd_a_r;
  logic [7:0]    d_rd_b_r;
`ifdef REGFILE_ARB_LOCK_EN
  logic          lock_r;
`endif

  logic       core_req_s;
  logic       starved_s;
  logic       dbg_win_s;
  logic       any_req_s;
  logic [1:0] op_s;
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [7:0] data_s;
  logic [3:0] a_sel_s;
  logic [3:0] b_sel_s;

  // Arbitration decision and winner payload, including pair-select shaping
  always_comb begin
`ifdef REGFILE_ARB_LOCK_EN
    core_req_s = bus.c_req && !(lock_r && bus.d_lock);
`else
    core_req_s = bus.c_req;
`endif
    starved_s = (int'(starve_r) == STARVE_LIMIT);
    dbg_win_s = bus.d_req && (!core_req_s || starved_s);
    any_req_s = core_req_s || bus.d_req;
    if (dbg_win_s) begin
      op_s   = bus.d_op;
      a_s    = bus.d_a;
      b_s    = bus.d_b;
      data_s = bus.d_data;
    end else begin
      op_s   = bus.c_op;
      a_s    = bus.c_a;
      b_s    = bus.c_b;
      data_s = bus.c_data;
    end
    // Pair ops address an even/odd register pair; B carries a 3-bit pair index
    if (op_s[1]) begin
      a_sel_s = {a_s[3:1], 1'b0};
      b_sel_s = {1'b0, b_s[2:0]};
    end else begin
      a_sel_s = a_s;
      b_sel_s = b_s;
    end
  end

  // Transaction FSM with registered strobes, acks and captured read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      starve_r <= '0;
      gnt_d_r  <= 1'b0;
      busy_r   <= 1'b0;
      c_ack_r  <= 1'b0;
      d_ack_r  <= 1'b0;
      we_r     <= 1'b0;
      add_r    <= 1'b0;
      move_r   <= 1'b0;
      a_sel_r  <= 4'h0;
      b_sel_r  <= 4'h0;
      data_r   <= 8'h00;
      c_rd_a_r <= 8'h00;
      c_rd_b_r <= 8'h00;
      d_rd_a_r <= 8'h00;
      d_rd_b_r <= 8'h00;
`ifdef REGFILE_ARB_LOCK_EN
      lock_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
          if (!bus.d_lock) begin
            lock_r <= 1'b0;
          end
`endif
          if (any_req_s) begin
            state_r <= ISSUE;
            busy_r  <= 1'b1;
            gnt_d_r <= dbg_win_s;
            a_sel_r <= a_sel_s;
            b_sel_r <= b_sel_s;
            data_r  <= data_s;
            we_r    <= (op_s == OP_WRITE);
            add_r   <= (op_s == OP_ADD);
            move_r  <= (op_s == OP_MOVE);
            if (dbg_win_s) begin
              starve_r <= '0;
`ifdef REGFILE_ARB_LOCK_EN
              lock_r   <= bus.d_lock;
`endif
            end else if (bus.d_req && !starved_s) begin
              starve_r <= starve_r + CW'(1);
            end else begin
              starve_r <= starve_r;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ISSUE: begin
          state_r <= ACK;
          we_r    <= 1'b0;
          add_r   <= 1'b0;
          move_r  <= 1'b0;
          c_ack_r <= !gnt_d_r;
          d_ack_r <= gnt_d_r;
        end
        ACK: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          if (gnt_d_r) begin
            d_rd_a_r <= bus.rf_outA;
            d_rd_b_r <= bus.rf_outB;
          end else begin
            c_rd_a_r <= bus.rf_outA;
            c_rd_b_r <= bus.rf_outB;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          we_r    <= 1'b0;
          add_r   <= 1'b0;
          move_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.c_ack       = c_ack_r;
  assign bus.d_ack       = d_ack_r;
  assign bus.rf_write_en = we_r;
  assign bus.rf_add      = add_r;
  assign bus.rf_move     = move_r;
  assign bus.rf_a_select = a_sel_r;
  assign bus.rf_b_select = b_sel_r;
  assign bus.rf_din      = data_r;
  assign bus.rf_constant = data_r;
  // Post-write register values are only visible in ACK, so rdata bypasses the hold register there
  assign bus.c_rdata_a   = (state_r == ACK && !gnt_d_r) ? bus.rf_outA : c_rd_a_r;
  assign bus.c_rdata_b   = (state_r == ACK && !gnt_d_r) ? bus.rf_outB : c_rd_b_r;
  assign bus.d_rdata_a   = (state_r == ACK &&  gnt_d_r) ? bus.rf_outA : d_rd_a_r;
  assign bus.d_rdata_b   = (state_r == ACK &&  gnt_d_r) ? bus.rf_outB : d_rd_b_r;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed table-driven bench for regfile_arbiter with a behavioural register file.
// Lock scenario runs only when REGFILE_ARB_LOCK_EN is defined.
module tb_regfile_arbiter;
  logic clk;
  logic reset;
  logic rf_init;
  int   total;
  int   bad;

  regfile_arbiter_if bus ();

  regfile_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: write, 16-bit pair add of a sign-extended constant, pair move
  logic [7:0] regs [16];
  logic [3:0] a_lo, a_hi, b_lo, b_hi;
  logic [15:0] pair_sum;
  assign a_lo = bus.rf_a_select;
  assign a_hi = {bus.rf_a_select[3:1], 1'b1};
  assign b_lo = {bus.rf_b_select[2:0], 1'b0};
  assign b_hi = {bus.rf_b_select[2:0], 1'b1};
  assign pair_sum = {regs[a_hi], regs[a_lo]} + {{8{bus.rf_constant[7]}}, bus.rf_constant};
  assign bus.rf_outA = regs[bus.rf_a_select];
  assign bus.rf_outB = regs[bus.rf_b_select];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'(i);
    end else begin
      if (bus.rf_write_en) regs[a_lo] <= bus.rf_din;
      if (bus.rf_add) begin
        regs[a_hi] <= pair_sum[15:8];
        regs[a_lo] <= pair_sum[7:0];
      end
      if (bus.rf_move) begin
        regs[a_hi] <= regs[b_hi];
        regs[a_lo] <= regs[b_lo];
      end
    end
  end

  typedef struct {
    logic       dbg;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [7:0] ra;
    logic [7:0] rb;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] exp_c_a, exp_c_b, exp_d_a, exp_d_b;

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    if (v.dbg) begin
      bus.d_req = 1'b1; bus.d_op = v.op; bus.d_a = v.a; bus.d_b = v.b; bus.d_data = v.data;
    end else begin
      bus.c_req = 1'b1; bus.c_op = v.op; bus.c_a = v.a; bus.c_b = v.b; bus.c_data = v.data;
    end
    @(posedge clk); @(negedge clk);
    chk("issue_busy", idx, bus.busy, 1);
    chk("issue_we", idx, bus.rf_write_en, v.op == 2'b01);
    chk("issue_add", idx, bus.rf_add, v.op == 2'b10);
    chk("issue_move", idx, bus.rf_move, v.op == 2'b11);
    chk("issue_asel", idx, bus.rf_a_select, v.ea);
    chk("issue_bsel", idx, bus.rf_b_select, v.eb);
    if (v.op == 2'b01) chk("issue_din", idx, bus.rf_din, v.data);
    if (v.op == 2'b10) chk("issue_const", idx, bus.rf_constant, v.data);
    chk("issue_acks", idx, {bus.c_ack, bus.d_ack}, 0);
    @(posedge clk); @(negedge clk);
    chk("ack_busy", idx, bus.busy, 1);
    chk("ack_strobes", idx, {bus.rf_write_en, bus.rf_add, bus.rf_move}, 0);
    if (v.dbg) begin
      chk("ack_d", idx, {bus.c_ack, bus.d_ack}, 2'b01);
      chk("d_rdata", idx, {bus.d_rdata_a, bus.d_rdata_b}, {v.ra, v.rb});
      chk("c_rdata_hold", idx, {bus.c_rdata_a, bus.c_rdata_b}, {exp_c_a, exp_c_b});
      exp_d_a = v.ra; exp_d_b = v.rb;
      bus.d_req = 1'b0;
    end else begin
      chk("ack_c", idx, {bus.c_ack, bus.d_ack}, 2'b10);
      chk("c_rdata", idx, {bus.c_rdata_a, bus.c_rdata_b}, {v.ra, v.rb});
      chk("d_rdata_hold", idx, {bus.d_rdata_a, bus.d_rdata_b}, {exp_d_a, exp_d_b});
      exp_c_a = v.ra; exp_c_b = v.rb;
      bus.c_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk("idle_busy", idx, bus.busy, 0);
    chk("idle_acks", idx, {bus.c_ack, bus.d_ack}, 0);
    chk("idle_rdata", idx, {bus.c_rdata_a, bus.c_rdata_b, bus.d_rdata_a, bus.d_rdata_b},
        {exp_c_a, exp_c_b, exp_d_a, exp_d_b});
  endtask

  initial begin
    total = 0; bad = 0;
    exp_c_a = 8'h00; exp_c_b = 8'h00; exp_d_a = 8'h00; exp_d_b = 8'h00;
    //        dbg   op     a      b      data   ea     eb     ra     rb
    vecs[0] = '{1'b0, 2'b01, 4'h3, 4'h0, 8'h5A, 4'h3, 4'h0, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 2'b01, 4'h4, 4'h0, 8'h00, 4'h4, 4'h0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 2'b01, 4'h5, 4'h4, 8'h01, 4'h5, 4'h4, 8'h01, 8'h00};
    vecs[3] = '{1'b1, 2'b10, 4'h5, 4'h0, 8'hFF, 4'h4, 4'h0, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 2'b11, 4'h2, 4'h6, 8'h00, 4'h2, 4'h6, 8'h0C, 8'h06};
    vecs[5] = '{1'b1, 2'b00, 4'h3, 4'h2, 8'h00, 4'h3, 4'h2, 8'h0D, 8'h0C};
    vecs[6] = '{1'b0, 2'b10, 4'h9, 4'hB, 8'h02, 4'h8, 4'h3, 8'h0A, 8'h0D};
    vecs[7] = '{1'b1, 2'b01, 4'hF, 4'hF, 8'hC3, 4'hF, 4'hF, 8'hC3, 8'hC3};
    vecs[8] = '{1'b0, 2'b00, 4'h0, 4'hF, 8'h00, 4'h0, 4'hF, 8'h00, 8'hC3};
    vecs[9] = '{1'b1, 2'b11, 4'hF, 4'hC, 8'h00, 4'hE, 4'h4, 8'h0A, 8'hFF};

    bus.c_req = 1'b0; bus.d_req = 1'b0; bus.c_op = 2'b00; bus.d_op = 2'b00;
    bus.c_a = 4'h0; bus.c_b = 4'h0; bus.d_a = 4'h0; bus.d_b = 4'h0;
    bus.c_data = 8'h00; bus.d_data = 8'h00;
`ifdef REGFILE_ARB_LOCK_EN
    bus.d_lock = 1'b0;
`endif
    rf_init = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", 0, bus.busy, 0);
    chk("rst_acks", 0, {bus.c_ack, bus.d_ack}, 0);
    chk("rst_strobes", 0, {bus.rf_write_en, bus.rf_add, bus.rf_move}, 0);
    chk("rst_sel", 0, {bus.rf_a_select, bus.rf_b_select, bus.rf_din}, 0);
    chk("rst_rdata", 0, {bus.c_rdata_a, bus.c_rdata_b, bus.d_rdata_a, bus.d_rdata_b}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_init = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // Core request withdrawn while a debug read is in flight must never be served
    bus.d_req = 1'b1; bus.d_op = 2'b00; bus.d_a = 4'h1; bus.d_b = 4'h1;
    @(posedge clk); @(negedge clk);
    bus.c_req = 1'b1; bus.c_op = 2'b01; bus.c_a = 4'h1; bus.c_data = 8'h77;
    @(posedge clk); @(negedge clk);
    chk("drop_dack", 0, bus.d_ack, 1);
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    exp_d_a = 8'h01; exp_d_b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("drop_idle", i, {bus.busy, bus.c_ack, bus.rf_write_en}, 0);
    end
    chk("drop_r1", 0, regs[1], 8'h01);

    // Reset in the middle of a core WRITE issue cycle
    bus.c_req = 1'b1; bus.c_op = 2'b01; bus.c_a = 4'h6; bus.c_b = 4'h0; bus.c_data = 8'hEE;
    @(posedge clk); @(negedge clk);
    chk("abort_we_pre", 0, bus.rf_write_en, 1);
    reset = 1'b0;
    #1;
    chk("abort_we", 0, {bus.rf_write_en, bus.busy, bus.c_ack}, 0);
    chk("abort_sel", 0, {bus.rf_a_select, bus.rf_din}, 0);
    chk("abort_rdata", 0, {bus.c_rdata_a, bus.c_rdata_b, bus.d_rdata_a, bus.d_rdata_b}, 0);
    @(posedge clk); @(negedge clk);
    chk("abort_noack", 0, {bus.c_ack, bus.busy}, 0);
    chk("abort_r6", 0, regs[6], 8'h06);
    bus.c_req = 1'b0;
    reset = 1'b1;
    exp_c_a = 8'h00; exp_c_b = 8'h00; exp_d_a = 8'h00; exp_d_b = 8'h00;
    @(posedge clk); @(negedge clk);
    chk("post_rst_idle", 0, {bus.busy, bus.c_ack, bus.d_ack}, 0);

    // Both requesting continuously: four core grants then one forced debug grant
    bus.c_op = 2'b00; bus.d_op = 2'b00; bus.c_a = 4'h0; bus.d_a = 4'h0;
    bus.c_req = 1'b1; bus.d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("starve_busy", i, bus.busy, 1);
      @(posedge clk); @(negedge clk);
      chk("starve_grant", i, {bus.c_ack, bus.d_ack}, ((i % 5) == 4) ? 2'b01 : 2'b10);
      if (i == 9) begin
        bus.c_req = 1'b0; bus.d_req = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("starve_end", 0, bus.busy, 0);

`ifdef REGFILE_ARB_LOCK_EN
    // Debug lock holds off the core for three debug transactions and until d_lock falls
    bus.d_lock = 1'b1; bus.d_req = 1'b1; bus.d_a = 4'h1; bus.d_b = 4'h2;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(posedge clk);
      @(posedge clk); @(negedge clk);
      if (k == 0) begin
        bus.c_req = 1'b1; bus.c_a = 4'h3;
      end
      @(posedge clk); @(negedge clk);
      chk("lock_dack", k, {bus.c_ack, bus.d_ack}, 2'b01);
    end
    bus.d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      chk("lock_hold", k, bus.busy, 0);
    end
    bus.d_lock = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lock_rel_busy", 0, bus.busy, 1);
    @(posedge clk); @(negedge clk);
    chk("lock_cack", 0, {bus.c_ack, bus.d_ack}, 2'b10);
    bus.c_req = 1'b0;
    @(posedge clk); @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost debug arbitrations before the debug requester is forced to win.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 c_req / d_req  input  1  core / debug request, held high until the matching ack.
REQ-005 c_op / d_op  input  2  operation: 00 READ, 01 WRITE, 10 PAIR_ADD, 11 PAIR_MOVE.
REQ-006 c_a, c_b / d_a, d_b  input  4 each  A and B register selects.
REQ-007 c_data / d_data  input  8  write data (WRITE) or signed constant (PAIR_ADD).
REQ-008 c_ack / d_ack  output  1  one-cycle completion pulse to that requester.
REQ-009 c_rdata_a, c_rdata_b / d_rdata_a, d_rdata_b  output  8 each  register values returned at ack.
REQ-010 rf_a_select, rf_b_select  output  4  to register file selects.
REQ-011 rf_din, rf_constant  output  8  to register file data and constant inputs.
REQ-012 rf_write_en, rf_add, rf_move  output  1  register file strobes.
REQ-013 rf_outA, rf_outB  input  8  register file read ports.
REQ-014 busy  output  1  high while a transaction is in flight.

Function
REQ-015 FSM states: IDLE, ISSUE, ACK; IDLE->ISSUE on any request, ISSUE->ACK always, ACK->IDLE always.
REQ-016 On the IDLE->ISSUE edge, the winner's op, a, b and data SHALL be latched; the requester may change its payload after its ack.
REQ-017 Arbitration: core only -> core; debug only -> debug; both -> core, unless the starve counter equals STARVE_LIMIT, then debug.
REQ-018 Starve counter: increments (saturating at STARVE_LIMIT) on each IDLE decision where debug requested and lost; clears when debug is granted.
REQ-019 In ISSUE, exactly one cycle: READ drives no strobe; WRITE asserts rf_write_en with rf_din=data; PAIR_ADD asserts rf_add with rf_constant=data; PAIR_MOVE asserts rf_move.
REQ-020 For PAIR_ADD and PAIR_MOVE, rf_a_select[0] SHALL be forced to 0, and rf_b_select SHALL carry b[2:0] zero-extended as the pair index.
REQ-021 rf_write_en, rf_add and rf_move SHALL be 0 outside ISSUE; rf selects and data outputs hold their latched values.
REQ-022 In ACK, rf_outA/rf_outB SHALL be captured into the granted side's rdata and that side's ack pulsed; other-side outputs unchanged.
REQ-023 rdata reflects post-write register state; it holds until the next ack to the same side.
REQ-024 Latency: request seen at edge n -> strobe during cycle n+1 -> ack during cycle n+2; maximum throughput one transaction per 3 cycles.
REQ-025 busy SHALL be high in ISSUE and ACK, low in IDLE.
REQ-026 A request deasserted before grant SHALL be dropped with no ack.

Reset
REQ-027 reset low SHALL immediately force IDLE, strobes 0, acks 0, busy 0, starve counter 0, all rdata 0, and selects/data 0.
REQ-028 Reset during ISSUE or ACK aborts the transaction with no ack; a strobe already sampled by the register file is not undone.

Configuration
REQ-029 With macro REGFILE_ARB_LOCK_EN defined, the block SHALL add input d_lock (1 bit), registered with the debug grant.
REQ-030 With REGFILE_ARB_LOCK_EN, while a debug grant occurred with d_lock high and d_lock remains high, core requests SHALL be ignored in IDLE; the lock releases the first IDLE cycle d_lock is low.
REQ-031 Without REGFILE_ARB_LOCK_EN, d_lock SHALL be absent and arbitration follows REQ-017 only.

Verification
REQ-032 Core WRITE a=3 data=0x5A -> rf_write_en high one cycle, c_ack at cycle n+2, c_rdata_a=0x5A.
REQ-033 Debug PAIR_ADD a=5 data=0xFF on pair r5:r4=0x0100 -> rf_a_select=4, rf_add pulse, d_rdata reads r4=0xFF.
REQ-034 Both requesting continuously, STARVE_LIMIT=4 -> grant pattern C,C,C,C,D repeating; no debug wait exceeds 4 losses.
REQ-035 Reset low during ISSUE of a core WRITE -> strobes 0 in the same cycle, no c_ack, busy 0.
REQ-036 Core PAIR_MOVE a=2 b=6 -> rf_move pulse, rf_a_select=2, rf_b_select=6, c_ack 2 cycles later.
REQ-037 With REGFILE_ARB_LOCK_EN, debug granted with d_lock=1 and core requesting -> three back-to-back debug transactions complete before the core grant, which occurs only after d_lock falls.
